// File: rtl/uart_tx_engine.sv
// FIFO-buffered UART transmitter with a configurable character format, driven by an external baud tick.
// The FIFO holds raw characters; each frame's format is captured when its character is popped.
module uart_tx_engine #(
    parameter  int unsigned FIFO_DEPTH = 16,
    parameter  int unsigned OVERSAMPLE = 16,
    localparam int unsigned PW         = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bclk,
    input  logic          tx_en,
    input  logic          write_en,
    input  logic [7:0]    data_in,
    input  logic [1:0]    data_bits,
    input  logic          parity_en,
    input  logic          parity_odd,
    input  logic          stop2,
    input  logic [PW:0]   thr_level,
    input  logic          ovf_clr,
    output logic          txd,
    output logic          tx_busy,
    output logic          tx_bclk_en,
    output logic          tx_done,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [PW:0]   fifo_count,
    output logic          tx_thr,
    output logic          overflow
);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

    state_t      state, state_d;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic [5:0]  tick, tick_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic        stop_cnt, stop_cnt_d;
    logic        txd_d, done_d;
    logic        push, pop, bit_end;
    logic [7:0]  head, head_mask, head_masked;
    logic        head_par;
    logic [7:0]  frame_data;
    logic [1:0]  frame_bits;
    logic        frame_par_en, frame_par, frame_stop2;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign fifo_count = wr_ptr - rd_ptr;
    assign tx_thr     = (fifo_count <= thr_level);
    assign tx_busy    = (state != IDLE) && (state != LOAD);
    assign tx_bclk_en = tx_busy;

    // Popping in LOAD frees a slot in the same cycle, so a full FIFO still accepts that push.
    assign pop  = (state == LOAD);
    assign push = write_en && (!fifo_full || pop);

    assign head    = mem[rd_ptr[PW-1:0]];
    assign bit_end = bclk && (tick == 6'(OVERSAMPLE - 1));

    always_comb begin
        head_mask = 8'hFF;
        case (data_bits)
            2'b00:   head_mask = 8'h1F;
            2'b01:   head_mask = 8'h3F;
            2'b10:   head_mask = 8'h7F;
            default: head_mask = 8'hFF;
        endcase
        head_masked = head & head_mask;
        head_par    = (^head_masked) ^ parity_odd;
    end

    always_comb begin
        state_d    = state;
        tick_d     = tick;
        bit_idx_d  = bit_idx;
        stop_cnt_d = stop_cnt;
        done_d     = 1'b0;
        if (tx_busy && bclk) begin
            tick_d = bit_end ? '0 : tick + 6'd1;
        end
        case (state)
            IDLE:   if (tx_en && !fifo_empty) state_d = LOAD;
            LOAD: begin
                state_d    = START;
                tick_d     = '0;
                bit_idx_d  = '0;
                stop_cnt_d = 1'b0;
            end
            START:  if (bit_end) state_d = DATA;
            DATA: begin
                // Last data bit index is width-1 = 4 + data_bits.
                if (bit_end) begin
                    if (bit_idx == {1'b1, frame_bits}) begin
                        state_d = frame_par_en ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: begin
                if (bit_end) begin
                    if (frame_stop2 && !stop_cnt) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // txd is registered from the next state so it changes together with the state.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = frame_data[bit_idx_d];
            PARITY:  txd_d = frame_par;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tick         <= '0;
            bit_idx      <= '0;
            stop_cnt     <= 1'b0;
            txd          <= 1'b1;
            tx_done      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow     <= 1'b0;
            frame_data   <= '0;
            frame_bits   <= '0;
            frame_par_en <= 1'b0;
            frame_par    <= 1'b0;
            frame_stop2  <= 1'b0;
        end else begin
            state    <= state_d;
            tick     <= tick_d;
            bit_idx  <= bit_idx_d;
            stop_cnt <= stop_cnt_d;
            txd      <= txd_d;
            tx_done  <= done_d;
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
            if (ovf_clr) begin
                overflow <= 1'b0;
            end else if (write_en && !push) begin
                overflow <= 1'b1;
            end
            if (state == LOAD) begin
                frame_data   <= head_masked;
                frame_bits   <= data_bits;
                frame_par_en <= parity_en;
                frame_par    <= head_par;
                frame_stop2  <= stop2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr[PW-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus queues expected serial frames, a monitor decodes txd.
module tb_uart_tx_engine;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned OS    = 16;
    localparam int unsigned PW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset, bclk, tx_en, write_en, parity_en, parity_odd, stop2, ovf_clr;
    logic [7:0]    data_in;
    logic [1:0]    data_bits;
    logic [PW:0]   thr_level;
    logic          txd, tx_busy, tx_bclk_en, tx_done, fifo_full, fifo_empty, tx_thr, overflow;
    logic [PW:0]   fifo_count;

    typedef struct {
        logic [11:0] bits;   // first transmitted bit at bits[nbits-1]
        int unsigned nbits;
    } frame_t;

    frame_t exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    logic   mon_busy = 1'b0;

    uart_tx_engine #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
        .clk(clk), .reset(reset), .bclk(bclk), .tx_en(tx_en), .write_en(write_en),
        .data_in(data_in), .data_bits(data_bits), .parity_en(parity_en),
        .parity_odd(parity_odd), .stop2(stop2), .thr_level(thr_level), .ovf_clr(ovf_clr),
        .txd(txd), .tx_busy(tx_busy), .tx_bclk_en(tx_bclk_en), .tx_done(tx_done),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .tx_thr(tx_thr), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic frame_t mk(logic [11:0] b, int unsigned n);
        frame_t f;
        f.bits  = b;
        f.nbits = n;
        return f;
    endfunction

    function automatic frame_t frame_of(logic [7:0] ch, logic [1:0] db, logic pe, logic po, logic s2);
        frame_t      f;
        int unsigned w = 5 + int'(db);
        logic        p = po;
        f.bits  = '0;
        f.nbits = 0;
        f.bits  = {f.bits[10:0], 1'b0}; f.nbits++;
        for (int unsigned i = 0; i < w; i++) begin
            f.bits = {f.bits[10:0], ch[i]}; f.nbits++;
            p = p ^ ch[i];
        end
        if (pe) begin f.bits = {f.bits[10:0], p}; f.nbits++; end
        f.bits = {f.bits[10:0], 1'b1}; f.nbits++;
        if (s2) begin f.bits = {f.bits[10:0], 1'b1}; f.nbits++; end
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        data_in  = d;
        write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        int unsigned n = 0;
        while (!(exp_q.size() == 0 && !mon_busy && !tx_busy && fifo_empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n >= budget), 32'd0);
    endtask

    // Monitor: decode each frame, checking every bit holds for exactly OS clocks and tx_done follows.
    initial begin
        logic        prev = 1'b1;
        logic        bitval, aborted, timing_ok;
        logic [11:0] got;
        frame_t      cur;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b1;
                continue;
            end
            if (prev && !txd) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_frame: got a start bit, expected no frame");
                end else begin
                    cur       = exp_q.pop_front();
                    mon_busy  = 1'b1;
                    got       = '0;
                    bitval    = 1'b0;
                    aborted   = 1'b0;
                    timing_ok = 1'b1;
                    for (int unsigned c = 0; c < cur.nbits * OS; c++) begin
                        if (c > 0) @(negedge clk);
                        if (reset) begin aborted = 1'b1; break; end
                        if (c % OS == 0) bitval = txd;
                        else if (txd !== bitval) timing_ok = 1'b0;
                        if (c % OS == OS / 2) got[cur.nbits - 1 - c / OS] = txd;
                        if (tx_done !== 1'b0 || tx_busy !== 1'b1) timing_ok = 1'b0;
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        if (reset) aborted = 1'b1;
                        else if (tx_done !== 1'b1 || tx_busy !== 1'b0) timing_ok = 1'b0;
                    end
                    if (!aborted) begin
                        n_cmp++;
                        if (got !== cur.bits) begin
                            n_err++;
                            $display("FAIL frame_bits: got %b expected %b (nbits %0d)", got, cur.bits, cur.nbits);
                        end
                        n_cmp++;
                        if (!timing_ok) begin
                            n_err++;
                            $display("FAIL frame_timing: got irregular bit/done/busy timing, expected %0d clk per bit then tx_done", OS);
                        end
                    end
                    mon_busy = 1'b0;
                end
            end
            prev = txd;
        end
    end

    initial begin
        #(400000 * 10);
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; bclk = 1'b1; tx_en = 1'b0; write_en = 1'b0; data_in = '0;
        data_bits = 2'b11; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        thr_level = '0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_txd", txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_bclk_en", tx_bclk_en, 0);
        check("rst_done", tx_done, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_thr", tx_thr, 1);
        reset = 1'b0;
        @(negedge clk);

        // 8N1 0xA5 with start latency
        tx_en = 1'b1;
        exp_q.push_back(mk(12'b0101001011, 10));
        push(8'hA5);
        check("push_empty", fifo_empty, 0);
        check("push_count", fifo_count, 1);
        check("push_txd_idle", txd, 1);
        @(negedge clk);
        check("load_txd", txd, 1);
        check("load_busy", tx_busy, 0);
        @(negedge clk);
        check("start_txd", txd, 0);
        check("start_busy", tx_busy, 1);
        check("start_bclk_en", tx_bclk_en, 1);
        check("start_count", fifo_count, 0);
        wait_done("8n1", 400);

        // 7E2 and 7O2 on 0xC1
        data_bits = 2'b10; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
        exp_q.push_back(mk(12'b01000001011, 11));
        push(8'hC1);
        wait_done("7e2", 400);
        parity_odd = 1'b1;
        exp_q.push_back(mk(12'b01000001111, 11));
        push(8'hC1);
        wait_done("7o2", 400);

        // Fill, overflow, drain in order
        data_bits = 2'b11; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        tx_en = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            exp_q.push_back(frame_of(8'(i), 2'b11, 1'b0, 1'b0, 1'b0));
            push(8'(i));
        end
        check("fill_full", fifo_full, 1);
        check("fill_count", fifo_count, 16);
        check("fill_ovf", overflow, 0);
        push(8'hEE);
        check("ovf_set", overflow, 1);
        check("ovf_count", fifo_count, 16);
        tx_en = 1'b1;
        wait_done("fill_drain", 16 * 200);
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);

        // Threshold: 6 queued, thr_level 4
        thr_level = 5'd4;
        tx_en = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            exp_q.push_back(frame_of(8'h30 + 8'(i), 2'b11, 1'b0, 1'b0, 1'b0));
            push(8'h30 + 8'(i));
        end
        check("thr_low", tx_thr, 0);
        check("thr_count6", fifo_count, 6);
        tx_en = 1'b1;
        begin
            int unsigned n = 0;
            while (!tx_thr && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("thr_rise_timeout", 32'(n >= 1000), 0);
            check("thr_rise_count", fifo_count, 4);
        end
        wait_done("thr", 6 * 200);
        thr_level = '0;

        // Push into a full FIFO in the LOAD cycle
        tx_en = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            exp_q.push_back(frame_of(8'h10 + 8'(i), 2'b11, 1'b0, 1'b0, 1'b0));
            push(8'h10 + 8'(i));
        end
        tx_en = 1'b1;
        @(negedge clk);
        exp_q.push_back(frame_of(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0));
        push(8'h5A);
        check("popush_count", fifo_count, 16);
        check("popush_ovf", overflow, 0);
        check("popush_full", fifo_full, 1);
        wait_done("popush", 17 * 200);

        // Reset during DATA bit 3
        exp_q.push_back(frame_of(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0));
        push(8'h3C);
        exp_q.push_back(frame_of(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0));
        push(8'hC3);
        repeat (70) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check("abort_txd", txd, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_count", fifo_count, 0);
        check("abort_empty", fifo_empty, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_q.push_back(frame_of(8'h96, 2'b11, 1'b0, 1'b0, 1'b0));
        push(8'h96);
        wait_done("post_reset", 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
